redirect_ctrl: RTL and testbench

Arbitrates all pipeline redirect sources: CP0 exception, second branch amend (PREMEM), first branch amend (decode). Selects the oldest winner, registers it, and holds one redirect request to the fetch unit until fetch accepts it. Also issues a one-cycle branch-predictor training/checkpoint-repair pulse per accepted branch redirect and keeps a mispredict counter. Sits between the flush-producing stages and IF/BPU.

---
 rtl/redirect_ctrl_if.sv | 62 ++++++
 rtl/redirect_ctrl.sv | 126 ++++++++++++
 tb/tb_redirect_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/redirect_ctrl_if.sv
// Bundle between the flush-producing stages / IF-BPU and redirect_ctrl.
// master drives flush sources and fetch ready; slave is the controller.
interface redirect_ctrl_if #(
  parameter int CKPT_W = 16,
  parameter int RA_W   = 4,
  parameter int CNT_W  = 16
);
  logic              CP0_excOccur_w_i;
  logic [31:0]       CP0_excDest_w_i;
  logic              SBA_flush_w_i;
  logic [31:0]       SBA_erroVAddr_w_i;
  logic [31:0]       SBA_corrDest_w_i;
  logic              SBA_corrTake_w_i;
  logic [CKPT_W-1:0] SBA_checkPoint_w_i;
  logic [RA_W-1:0]   SBA_repairAction_w_i;
  logic              FBA_flush_w_i;
  logic [31:0]       FBA_erroVAddr_w_i;
  logic [31:0]       FBA_corrDest_w_i;
  logic              FBA_corrTake_w_i;
  logic [CKPT_W-1:0] FBA_checkPoint_w_i;
  logic [RA_W-1:0]   FBA_repairAction_w_i;
  logic              IF_redirectReady_w_i;

  // Handshake: a redirect transfers on any rising edge where RDC_valid_o and
  // IF_redirectReady_w_i are both high; ready is ignored while valid is low.
  logic              RDC_valid_o;
  logic [31:0]       RDC_dest_o;
  logic [1:0]        RDC_src_o;
  logic              RDC_busy_o;
  logic              RDC_bpuValid_o;
  logic [31:0]       RDC_bpuPC_o;
  logic [31:0]       RDC_bpuDest_o;
  logic              RDC_bpuTake_o;
  logic [CKPT_W-1:0] RDC_bpuCkpt_o;
  logic [RA_W-1:0]   RDC_bpuRepair_o;
  logic [CNT_W-1:0]  RDC_mispredCnt_o;
  logic              dbg_state;

  modport master (
    output CP0_excOccur_w_i, CP0_excDest_w_i,
    output SBA_flush_w_i, SBA_erroVAddr_w_i, SBA_corrDest_w_i, SBA_corrTake_w_i,
    output SBA_checkPoint_w_i, SBA_repairAction_w_i,
    output FBA_flush_w_i, FBA_erroVAddr_w_i, FBA_corrDest_w_i, FBA_corrTake_w_i,
    output FBA_checkPoint_w_i, FBA_repairAction_w_i,
    output IF_redirectReady_w_i,
    input  RDC_valid_o, RDC_dest_o, RDC_src_o, RDC_busy_o,
    input  RDC_bpuValid_o, RDC_bpuPC_o, RDC_bpuDest_o, RDC_bpuTake_o,
    input  RDC_bpuCkpt_o, RDC_bpuRepair_o, RDC_mispredCnt_o, dbg_state
  );

  modport slave (
    input  CP0_excOccur_w_i, CP0_excDest_w_i,
    input  SBA_flush_w_i, SBA_erroVAddr_w_i, SBA_corrDest_w_i, SBA_corrTake_w_i,
    input  SBA_checkPoint_w_i, SBA_repairAction_w_i,
    input  FBA_flush_w_i, FBA_erroVAddr_w_i, FBA_corrDest_w_i, FBA_corrTake_w_i,
    input  FBA_checkPoint_w_i, FBA_repairAction_w_i,
    input  IF_redirectReady_w_i,
    output RDC_valid_o, RDC_dest_o, RDC_src_o, RDC_busy_o,
    output RDC_bpuValid_o, RDC_bpuPC_o, RDC_bpuDest_o, RDC_bpuTake_o,
    output RDC_bpuCkpt_o, RDC_bpuRepair_o, RDC_mispredCnt_o, dbg_state
  );
endinterface

// File: rtl/redirect_ctrl.sv
// Picks the oldest pending redirect (CP0 > SBA > FBA), holds it for fetch,
// and pulses branch-predictor training when a branch redirect is accepted.
module redirect_ctrl #(
  parameter int CKPT_W = 16,
  parameter int RA_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  redirect_ctrl_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t            state;
  logic [1:0]        src_q;
  logic [31:0]       dest_q;
  logic [31:0]       pc_q;
  logic              take_q;
  logic [CKPT_W-1:0] ckpt_q;
  logic [RA_W-1:0]   ra_q;

  logic              bpu_valid_q;
  logic [31:0]       bpu_pc_q;
  logic [31:0]       bpu_dest_q;
  logic              bpu_take_q;
  logic [CKPT_W-1:0] bpu_ckpt_q;
  logic [RA_W-1:0]   bpu_ra_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [1:0]        cand_src;
  logic [31:0]       cand_dest;
  logic [31:0]       cand_pc;
  logic              cand_take;
  logic [CKPT_W-1:0] cand_ckpt;
  logic [RA_W-1:0]   cand_ra;
  logic              accept;
  logic              capture;

  always_comb begin
    cand_src  = 2'd0;
    cand_dest = 32'd0;
    cand_pc   = 32'd0;
    cand_take = 1'b0;
    cand_ckpt = '0;
    cand_ra   = '0;
    if (bus.CP0_excOccur_w_i) begin
      cand_src  = 2'd3;
      cand_dest = bus.CP0_excDest_w_i;
    end else if (bus.SBA_flush_w_i) begin
      cand_src  = 2'd2;
      cand_dest = bus.SBA_corrDest_w_i;
      cand_pc   = bus.SBA_erroVAddr_w_i;
      cand_take = bus.SBA_corrTake_w_i;
      cand_ckpt = bus.SBA_checkPoint_w_i;
      cand_ra   = bus.SBA_repairAction_w_i;
    end else if (bus.FBA_flush_w_i) begin
      cand_src  = 2'd1;
      cand_dest = bus.FBA_corrDest_w_i;
      cand_pc   = bus.FBA_erroVAddr_w_i;
      cand_take = bus.FBA_corrTake_w_i;
      cand_ckpt = bus.FBA_checkPoint_w_i;
      cand_ra   = bus.FBA_repairAction_w_i;
    end
  end

  assign accept  = (state == PEND) && bus.IF_redirectReady_w_i;
  // A lower-or-equal candidate is younger and already flushed by the pending one.
  assign capture = (cand_src != 2'd0) &&
                   ((state == IDLE) || accept || (cand_src > src_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      src_q       <= 2'd0;
      dest_q      <= 32'd0;
      pc_q        <= 32'd0;
      take_q      <= 1'b0;
      ckpt_q      <= '0;
      ra_q        <= '0;
      bpu_valid_q <= 1'b0;
      bpu_pc_q    <= 32'd0;
      bpu_dest_q  <= 32'd0;
      bpu_take_q  <= 1'b0;
      bpu_ckpt_q  <= '0;
      bpu_ra_q    <= '0;
      cnt_q       <= '0;
    end else begin
      bpu_valid_q <= 1'b0;
      if (accept && (src_q == 2'd1 || src_q == 2'd2)) begin
        bpu_valid_q <= 1'b1;
        bpu_pc_q    <= pc_q;
        bpu_dest_q  <= dest_q;
        bpu_take_q  <= take_q;
        bpu_ckpt_q  <= ckpt_q;
        bpu_ra_q    <= ra_q;
        cnt_q       <= cnt_q + 1'b1;
      end
      if (capture) begin
        state  <= PEND;
        src_q  <= cand_src;
        dest_q <= cand_dest;
        pc_q   <= cand_pc;
        take_q <= cand_take;
        ckpt_q <= cand_ckpt;
        ra_q   <= cand_ra;
      end else if (accept) begin
        state  <= IDLE;
        src_q  <= 2'd0;
        dest_q <= 32'd0;
      end
    end
  end

  assign bus.RDC_valid_o      = (state == PEND);
  assign bus.RDC_busy_o       = (state == PEND);
  assign bus.RDC_dest_o       = dest_q;
  assign bus.RDC_src_o        = src_q;
  assign bus.RDC_bpuValid_o   = bpu_valid_q;
  assign bus.RDC_bpuPC_o      = bpu_pc_q;
  assign bus.RDC_bpuDest_o    = bpu_dest_q;
  assign bus.RDC_bpuTake_o    = bpu_take_q;
  assign bus.RDC_bpuCkpt_o    = bpu_ckpt_q;
  assign bus.RDC_bpuRepair_o  = bpu_ra_q;
  assign bus.RDC_mispredCnt_o = cnt_q;
  assign bus.dbg_state        = state;
endmodule

// File: tb/tb_redirect_ctrl.sv
// Bench for redirect_ctrl: directed scenarios plus random traffic against a
// transaction-level model of pending request, training pulses and counter.
module tb_redirect_ctrl;
  localparam int CKPT_W = 16;
  localparam int RA_W   = 4;
  localparam int CNT_W  = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  redirect_ctrl_if #(.CKPT_W(CKPT_W), .RA_W(RA_W), .CNT_W(CNT_W)) rif ();
  redirect_ctrl #(.CKPT_W(CKPT_W), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(rif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the pending request record and the last training pulse.
  bit               m_pend;
  int               m_src;
  logic [31:0]      m_dest, m_pc;
  logic             m_take;
  logic [CKPT_W-1:0] m_ckpt;
  logic [RA_W-1:0]  m_ra;
  bit               m_pv;
  logic [31:0]      m_pdest, m_ppc;
  logic             m_ptake;
  logic [CKPT_W-1:0] m_pckpt;
  logic [RA_W-1:0]  m_pra;
  logic [CNT_W-1:0] m_cnt;

  task automatic model_reset();
    m_pend = 0; m_src = 0; m_dest = 0; m_pc = 0; m_take = 0; m_ckpt = 0; m_ra = 0;
    m_pv = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int c;
    logic [31:0] cd, cp;
    logic ct;
    logic [CKPT_W-1:0] ck;
    logic [RA_W-1:0] cr;
    c = 0; cd = 0; cp = 0; ct = 0; ck = 0; cr = 0;
    if (rif.CP0_excOccur_w_i) begin
      c = 3; cd = rif.CP0_excDest_w_i;
    end else if (rif.SBA_flush_w_i) begin
      c = 2; cd = rif.SBA_corrDest_w_i; cp = rif.SBA_erroVAddr_w_i;
      ct = rif.SBA_corrTake_w_i; ck = rif.SBA_checkPoint_w_i; cr = rif.SBA_repairAction_w_i;
    end else if (rif.FBA_flush_w_i) begin
      c = 1; cd = rif.FBA_corrDest_w_i; cp = rif.FBA_erroVAddr_w_i;
      ct = rif.FBA_corrTake_w_i; ck = rif.FBA_checkPoint_w_i; cr = rif.FBA_repairAction_w_i;
    end
    m_pv = 0;
    if (m_pend && rif.IF_redirectReady_w_i) begin
      if (m_src == 1 || m_src == 2) begin
        m_pv = 1; m_pdest = m_dest; m_ppc = m_pc; m_ptake = m_take;
        m_pckpt = m_ckpt; m_pra = m_ra; m_cnt = m_cnt + 1'b1;
      end
      m_pend = 0; m_src = 0;
    end
    if (c != 0 && (!m_pend || c > m_src)) begin
      m_pend = 1; m_src = c; m_dest = cd; m_pc = cp; m_take = ct; m_ckpt = ck; m_ra = cr;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    rif.CP0_excOccur_w_i = 0; rif.CP0_excDest_w_i = 0;
    rif.SBA_flush_w_i = 0; rif.SBA_erroVAddr_w_i = 0; rif.SBA_corrDest_w_i = 0;
    rif.SBA_corrTake_w_i = 0; rif.SBA_checkPoint_w_i = 0; rif.SBA_repairAction_w_i = 0;
    rif.FBA_flush_w_i = 0; rif.FBA_erroVAddr_w_i = 0; rif.FBA_corrDest_w_i = 0;
    rif.FBA_corrTake_w_i = 0; rif.FBA_checkPoint_w_i = 0; rif.FBA_repairAction_w_i = 0;
    rif.IF_redirectReady_w_i = 0;
  endtask

  task automatic set_fba(input logic [31:0] dest, input logic [31:0] pc, input logic take,
                         input logic [CKPT_W-1:0] ck, input logic [RA_W-1:0] ra);
    rif.FBA_flush_w_i = 1; rif.FBA_corrDest_w_i = dest; rif.FBA_erroVAddr_w_i = pc;
    rif.FBA_corrTake_w_i = take; rif.FBA_checkPoint_w_i = ck; rif.FBA_repairAction_w_i = ra;
  endtask

  task automatic set_sba(input logic [31:0] dest, input logic [31:0] pc, input logic take,
                         input logic [CKPT_W-1:0] ck, input logic [RA_W-1:0] ra);
    rif.SBA_flush_w_i = 1; rif.SBA_corrDest_w_i = dest; rif.SBA_erroVAddr_w_i = pc;
    rif.SBA_corrTake_w_i = take; rif.SBA_checkPoint_w_i = ck; rif.SBA_repairAction_w_i = ra;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 0;
    model_reset();
    #12;
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    model_reset();
    #3;
    n_checks++;
    if (rif.RDC_valid_o !== 1'b0 || rif.RDC_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b/%b expected 0/0", rif.RDC_valid_o, rif.RDC_busy_o);
    end
    n_checks++;
    if (rif.RDC_mispredCnt_o !== 16'd0 || rif.RDC_src_o !== 2'd0) begin
      n_fail++; $display("FAIL reset_cnt_src: got %h/%0d expected 0/0", rif.RDC_mispredCnt_o, rif.RDC_src_o);
    end
    #10; rst = 1;
    @(negedge clk);
    set_fba(32'h0000_1000, 32'h0000_0ff0, 1'b1, 16'h1234, 4'h1);
    cycle();
    clear_inputs();
    n_checks++;
    if (rif.RDC_valid_o !== 1'b1 || rif.RDC_dest_o !== 32'h0000_1000) begin
      n_fail++; $display("FAIL reset_pre_pend: got valid %b dest %h expected 1 00001000", rif.RDC_valid_o, rif.RDC_dest_o);
    end
    #2; rst = 0; model_reset();
    #1;
    n_checks++;
    if (rif.RDC_valid_o !== 1'b0 || rif.RDC_dest_o !== 32'd0 || rif.RDC_src_o !== 2'd0 || rif.RDC_bpuValid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_pend: got valid %b dest %h src %0d expected all 0", rif.RDC_valid_o, rif.RDC_dest_o, rif.RDC_src_o);
    end
    rif.IF_redirectReady_w_i = 1;
    #4; rst = 1;
    cycle(); cycle();
    n_checks++;
    if (rif.RDC_bpuValid_o !== 1'b0 || rif.RDC_mispredCnt_o !== 16'd0 || rif.RDC_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_after_release: got bpu %b cnt %h valid %b expected 0 0 0", rif.RDC_bpuValid_o, rif.RDC_mispredCnt_o, rif.RDC_valid_o);
    end
    clear_inputs();
  endtask

  task automatic test_fba_basic();
    int vcnt;
    apply_reset();
    set_fba(32'hBFC0_0100, 32'hBFC0_00F0, 1'b1, 16'hA5A5, 4'h3);
    cycle();
    clear_inputs();
    n_checks++;
    if (rif.RDC_src_o !== 2'd1 || rif.RDC_dest_o !== 32'hBFC0_0100) begin
      n_fail++; $display("FAIL fba_capture: got src %0d dest %h expected 1 bfc00100", rif.RDC_src_o, rif.RDC_dest_o);
    end
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (rif.RDC_valid_o === 1'b1) vcnt++;
      rif.IF_redirectReady_w_i = (i == 3);
      cycle();
    end
    rif.IF_redirectReady_w_i = 0;
    n_checks++;
    if (vcnt !== 4 || rif.RDC_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL fba_valid_len: got %0d cycles, valid now %b expected 4, 0", vcnt, rif.RDC_valid_o);
    end
    n_checks++;
    if (rif.RDC_bpuValid_o !== 1'b1 || rif.RDC_bpuPC_o !== 32'hBFC0_00F0 || rif.RDC_bpuDest_o !== 32'hBFC0_0100 ||
        rif.RDC_bpuTake_o !== 1'b1 || rif.RDC_bpuCkpt_o !== 16'hA5A5 || rif.RDC_bpuRepair_o !== 4'h3) begin
      n_fail++; $display("FAIL fba_pulse: got v%b pc %h dest %h take %b ck %h ra %h", rif.RDC_bpuValid_o,
                         rif.RDC_bpuPC_o, rif.RDC_bpuDest_o, rif.RDC_bpuTake_o, rif.RDC_bpuCkpt_o, rif.RDC_bpuRepair_o);
    end
    n_checks++;
    if (rif.RDC_mispredCnt_o !== 16'd1) begin
      n_fail++; $display("FAIL fba_cnt: got %h expected 0001", rif.RDC_mispredCnt_o);
    end
    cycle();
    n_checks++;
    if (rif.RDC_bpuValid_o !== 1'b0) begin
      n_fail++; $display("FAIL fba_pulse_len: got %b expected 0", rif.RDC_bpuValid_o);
    end
  endtask

  task automatic test_sba_overwrite();
    apply_reset();
    set_fba(32'h1234_0000, 32'h1233_FFF0, 1'b0, 16'h0F0F, 4'h2);
    cycle();
    clear_inputs();
    set_sba(32'h8000_0040, 32'h8000_0020, 1'b0, 16'h1111, 4'h1);
    cycle();
    clear_inputs();
    n_checks++;
    if (rif.RDC_src_o !== 2'd2 || rif.RDC_dest_o !== 32'h8000_0040) begin
      n_fail++; $display("FAIL sba_overwrite: got src %0d dest %h expected 2 80000040", rif.RDC_src_o, rif.RDC_dest_o);
    end
    rif.IF_redirectReady_w_i = 1;
    cycle();
    clear_inputs();
    n_checks++;
    if (rif.RDC_bpuValid_o !== 1'b1 || rif.RDC_bpuPC_o !== 32'h8000_0020 || rif.RDC_bpuDest_o !== 32'h8000_0040 ||
        rif.RDC_bpuTake_o !== 1'b0 || rif.RDC_bpuCkpt_o !== 16'h1111 || rif.RDC_bpuRepair_o !== 4'h1 ||
        rif.RDC_mispredCnt_o !== 16'd1) begin
      n_fail++; $display("FAIL sba_pulse: got v%b pc %h dest %h ck %h cnt %h expected 1 80000020 80000040 1111 0001",
                         rif.RDC_bpuValid_o, rif.RDC_bpuPC_o, rif.RDC_bpuDest_o, rif.RDC_bpuCkpt_o, rif.RDC_mispredCnt_o);
    end
  endtask

  task automatic test_cp0_overwrite();
    apply_reset();
    set_sba(32'h8000_0040, 32'h8000_0020, 1'b1, 16'h2222, 4'h1);
    cycle();
    clear_inputs();
    rif.CP0_excOccur_w_i = 1; rif.CP0_excDest_w_i = 32'hBFC0_0380;
    set_fba(32'h0000_5555, 32'h0000_5550, 1'b1, 16'h3333, 4'h1);
    cycle();
    clear_inputs();
    n_checks++;
    if (rif.RDC_src_o !== 2'd3 || rif.RDC_dest_o !== 32'hBFC0_0380) begin
      n_fail++; $display("FAIL cp0_overwrite: got src %0d dest %h expected 3 bfc00380", rif.RDC_src_o, rif.RDC_dest_o);
    end
    rif.IF_redirectReady_w_i = 1;
    cycle();
    clear_inputs();
    n_checks++;
    if (rif.RDC_bpuValid_o !== 1'b0 || rif.RDC_mispredCnt_o !== 16'd0 || rif.RDC_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL cp0_accept: got bpu %b cnt %h valid %b expected 0 0000 0",
                         rif.RDC_bpuValid_o, rif.RDC_mispredCnt_o, rif.RDC_valid_o);
    end
  endtask

  task automatic test_drop_younger();
    apply_reset();
    set_sba(32'h8000_0040, 32'h8000_0020, 1'b1, 16'h4444, 4'h1);
    cycle();
    clear_inputs();
    set_fba(32'h0000_2222, 32'h0000_2220, 1'b0, 16'h5555, 4'h0);
    cycle();
    clear_inputs();
    n_checks++;
    if (rif.RDC_src_o !== 2'd2 || rif.RDC_dest_o !== 32'h8000_0040) begin
      n_fail++; $display("FAIL drop_fba: got src %0d dest %h expected 2 80000040", rif.RDC_src_o, rif.RDC_dest_o);
    end
    set_sba(32'h9000_0000, 32'h8FFF_FFF0, 1'b0, 16'h6666, 4'h2);
    cycle();
    clear_inputs();
    n_checks++;
    if (rif.RDC_src_o !== 2'd2 || rif.RDC_dest_o !== 32'h8000_0040) begin
      n_fail++; $display("FAIL drop_equal: got src %0d dest %h expected 2 80000040", rif.RDC_src_o, rif.RDC_dest_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev_dest, cur_dest;
    apply_reset();
    prev_dest = 32'h0001_0000;
    set_fba(prev_dest, 32'h0000_0100, 1'b1, 16'h0001, 4'h1);
    cycle();
    for (int i = 1; i <= 65536; i++) begin
      cur_dest = 32'h0001_0000 + (i << 2);
      set_fba(cur_dest, 32'h0000_0100 + i, i[0], i[15:0], 4'h1);
      rif.IF_redirectReady_w_i = 1;
      cycle();
      if (i < 4) begin
        n_checks++;
        if (rif.RDC_bpuValid_o !== 1'b1 || rif.RDC_bpuDest_o !== prev_dest ||
            rif.RDC_valid_o !== 1'b1 || rif.RDC_dest_o !== cur_dest) begin
          n_fail++; $display("FAIL b2b_step%0d: got bpu %b/%h valid %b dest %h expected 1/%h 1 %h", i,
                             rif.RDC_bpuValid_o, rif.RDC_bpuDest_o, rif.RDC_valid_o, rif.RDC_dest_o, prev_dest, cur_dest);
        end
      end
      if (i == 65535) begin
        n_checks++;
        if (rif.RDC_mispredCnt_o !== 16'hFFFF) begin
          n_fail++; $display("FAIL b2b_cnt_max: got %h expected ffff", rif.RDC_mispredCnt_o);
        end
      end
      prev_dest = cur_dest;
    end
    n_checks++;
    if (rif.RDC_mispredCnt_o !== 16'h0000 || rif.RDC_bpuValid_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_cnt_wrap: got cnt %h bpu %b expected 0000 1", rif.RDC_mispredCnt_o, rif.RDC_bpuValid_o);
    end
    clear_inputs();
    rif.IF_redirectReady_w_i = 1;
    cycle();
    clear_inputs();
    n_checks++;
    if (rif.RDC_valid_o !== 1'b0 || rif.RDC_bpuDest_o !== prev_dest || rif.RDC_mispredCnt_o !== 16'd1) begin
      n_fail++; $display("FAIL b2b_drain: got valid %b bpuDest %h cnt %h expected 0 %h 0001",
                         rif.RDC_valid_o, rif.RDC_bpuDest_o, rif.RDC_mispredCnt_o, prev_dest);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      rif.CP0_excOccur_w_i = ($urandom_range(0, 7) == 0);
      rif.CP0_excDest_w_i = $urandom;
      rif.SBA_flush_w_i = ($urandom_range(0, 3) == 0);
      rif.SBA_corrDest_w_i = $urandom; rif.SBA_erroVAddr_w_i = $urandom;
      rif.SBA_corrTake_w_i = $urandom_range(0, 1);
      rif.SBA_checkPoint_w_i = CKPT_W'($urandom); rif.SBA_repairAction_w_i = RA_W'($urandom);
      rif.FBA_flush_w_i = ($urandom_range(0, 2) == 0);
      rif.FBA_corrDest_w_i = $urandom; rif.FBA_erroVAddr_w_i = $urandom;
      rif.FBA_corrTake_w_i = $urandom_range(0, 1);
      rif.FBA_checkPoint_w_i = CKPT_W'($urandom); rif.FBA_repairAction_w_i = RA_W'($urandom);
      rif.IF_redirectReady_w_i = $urandom_range(0, 1);
      cycle();
      n_checks++;
      if (rif.RDC_valid_o !== m_pend || rif.RDC_busy_o !== m_pend || rif.RDC_src_o !== 2'(m_src)) begin
        n_fail++; $display("FAIL rand_state@%0d: got valid %b busy %b src %0d expected %b %b %0d", i,
                           rif.RDC_valid_o, rif.RDC_busy_o, rif.RDC_src_o, m_pend, m_pend, m_src);
      end
      n_checks++;
      if (m_pend && rif.RDC_dest_o !== m_dest) begin
        n_fail++; $display("FAIL rand_dest@%0d: got %h expected %h", i, rif.RDC_dest_o, m_dest);
      end
      n_checks++;
      if (rif.RDC_bpuValid_o !== m_pv || rif.RDC_mispredCnt_o !== m_cnt) begin
        n_fail++; $display("FAIL rand_pulse@%0d: got bpu %b cnt %h expected %b %h", i,
                           rif.RDC_bpuValid_o, rif.RDC_mispredCnt_o, m_pv, m_cnt);
      end
      n_checks++;
      if (m_pv && (rif.RDC_bpuPC_o !== m_ppc || rif.RDC_bpuDest_o !== m_pdest || rif.RDC_bpuTake_o !== m_ptake ||
                   rif.RDC_bpuCkpt_o !== m_pckpt || rif.RDC_bpuRepair_o !== m_pra)) begin
        n_fail++; $display("FAIL rand_fields@%0d: got pc %h dest %h take %b ck %h ra %h expected %h %h %b %h %h", i,
                           rif.RDC_bpuPC_o, rif.RDC_bpuDest_o, rif.RDC_bpuTake_o, rif.RDC_bpuCkpt_o, rif.RDC_bpuRepair_o,
                           m_ppc, m_pdest, m_ptake, m_pckpt, m_pra);
      end
    end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1;
    clear_inputs();
    model_reset();
    test_reset();
    test_fba_basic();
    test_sba_overwrite();
    test_cp0_overwrite();
    test_drop_younger();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
